dec_trigger_ctl: RTL

Owns the four debug-trigger CSR sets (tselect/tdata1/tdata2) and drives the per-trigger packets to the decode-stage PC-match logic. Qualifies writeback-stage match vectors for i0/i1, applies chaining (pairs 0-1, 2-3), records hit bits and raises one action request to the TLU. The request is held until acknowledged, then matches are blocked for a flush window. Sits between the TLU CSR path and decode trigger matching.

---
 rtl/dec_trigger_ctl_pkg.sv | 35 +++
 rtl/dec_trigger_ctl_reg.sv | 50 +++++
 rtl/dec_trigger_ctl.sv | 104 ++++++++++
 3 files changed

// File: rtl/dec_trigger_ctl_pkg.sv
// swerv_types: shared trigger packet, tdata1 field positions, CSR address map and trigger FSM states.
package swerv_types;

   typedef struct packed {
      logic        select;
      logic        match;
      logic        store;
      logic        load;
      logic        execute;
      logic        m;
      logic [31:0] tdata2;
   } trigger_pkt_t;

   localparam int TD1_DMODE   = 27;
   localparam int TD1_HIT     = 20;
   localparam int TD1_SELECT  = 19;
   localparam int TD1_ACTION  = 12;
   localparam int TD1_CHAIN   = 11;
   localparam int TD1_MATCH   = 7;
   localparam int TD1_M       = 6;
   localparam int TD1_EXECUTE = 2;
   localparam int TD1_STORE   = 1;
   localparam int TD1_LOAD    = 0;

   localparam logic [3:0]  TD1_TYPE  = 4'd2;
   localparam logic [31:0] TD1_WMASK = 32'h0818_18C7;

   localparam logic [1:0] CSR_TSELECT = 2'd0;
   localparam logic [1:0] CSR_TDATA1  = 2'd1;
   localparam logic [1:0] CSR_TDATA2  = 2'd2;
   localparam logic [1:0] CSR_HITCNT  = 2'd3;

   typedef enum logic [1:0] {IDLE, PEND, FLUSH} trig_state_t;

endpackage

// File: rtl/dec_trigger_ctl_reg.sv
// dec_trigger_reg: one trigger's tdata1/tdata2/hit state, dmode write lock and packet drive.
// Optional 16-bit saturating hit counter under DEC_TRIGGER_HITCNT_EN.
module dec_trigger_reg
   import swerv_types::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         dbg_mode,
   input  logic         wr_en,
   input  logic [1:0]   addr,
   input  logic [31:0]  wr_data,
   input  logic         hit_set,
   input  logic         fire,
   output logic [31:0]  tdata1,
   output logic [31:0]  tdata2,
   output logic [15:0]  hit_cnt,
   output trigger_pkt_t pkt
);
   logic [31:0] t1_q, t2_q, t1_wr;
   logic        locked;
   assign locked = t1_q[TD1_DMODE] & ~dbg_mode;
   // dmode only takes the written value from debug mode; otherwise it keeps its (necessarily 0) value
   assign t1_wr = (wr_data & TD1_WMASK & ~(32'd1 << TD1_DMODE)) |
                  ((dbg_mode ? wr_data : t1_q) & (32'd1 << TD1_DMODE));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         t1_q <= '0;
         t2_q <= '0;
      end else begin
         if (wr_en && addr == CSR_TDATA1 && !locked) t1_q <= t1_wr | (32'(hit_set) << TD1_HIT);
         else if (hit_set) t1_q[TD1_HIT] <= 1'b1;
         if (wr_en && addr == CSR_TDATA2 && !locked) t2_q <= wr_data;
      end
   assign tdata1 = t1_q | {TD1_TYPE, 28'd0};
   assign tdata2 = t2_q;
   assign pkt = '{select: t1_q[TD1_SELECT], match: t1_q[TD1_MATCH], store: t1_q[TD1_STORE],
                  load: t1_q[TD1_LOAD], execute: t1_q[TD1_EXECUTE], m: t1_q[TD1_M], tdata2: t2_q};
`ifdef DEC_TRIGGER_HITCNT_EN
   logic [15:0] cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else if (wr_en && addr == CSR_HITCNT) cnt_q <= wr_data[15:0];
      else if (fire && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
   assign hit_cnt = cnt_q;
`else
   logic unused_fire;
   assign unused_fire = fire;
   assign hit_cnt = '0;
`endif
endmodule

// File: rtl/dec_trigger_ctl.sv
// dec_trigger_ctl: debug-trigger CSRs, chaining, i0/i1 priority and the action request FSM to the TLU.
// Build option DEC_TRIGGER_HITCNT_EN adds per-trigger hit counters at csr_addr 3.
module dec_trigger_ctl
   import swerv_types::*;
#(
   parameter int NUM_TRIG     = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        csr_wr_en,
   input  logic [1:0]                  csr_addr,
   input  logic [31:0]                 csr_wr_data,
   output logic [31:0]                 csr_rd_data,
   input  logic                        dbg_mode,
   output trigger_pkt_t [NUM_TRIG-1:0] trigger_pkt_any,
   input  logic [NUM_TRIG-1:0]         i0_trig_match_wb,
   input  logic                        i0_valid_wb,
   input  logic [NUM_TRIG-1:0]         i1_trig_match_wb,
   input  logic                        i1_valid_wb,
   output logic                        trig_action_req,
   output logic                        trig_action_halt,
   output logic                        trig_action_i1,
   input  logic                        trig_action_ack
);
   logic [1:0]          tsel_q;
   logic [31:0]         t1_all [NUM_TRIG];
   logic [31:0]         t2_all [NUM_TRIG];
   logic [15:0]         cnt_all [NUM_TRIG];
   logic [NUM_TRIG-1:0] q0, q1, f0, f1, win, act, hit_set;
   trig_state_t         state_q, state_n;
   logic [2:0]          cnt_q, cnt_n;
   logic                halt_q, halt_n, i1_q, i1_n;
   always_ff @(posedge clk or posedge rst)
      if (rst) tsel_q <= '0;
      else if (csr_wr_en && csr_addr == CSR_TSELECT) tsel_q <= csr_wr_data[1:0];
   assign q0 = i0_valid_wb ? i0_trig_match_wb : '0;
   assign q1 = i1_valid_wb ? i1_trig_match_wb : '0;
   for (genvar k = 0; k < NUM_TRIG / 2; k++) begin : g_chain
      assign f0[2*k]   = q0[2*k]   & (~t1_all[2*k][TD1_CHAIN] | q0[2*k+1]);
      assign f0[2*k+1] = q0[2*k+1] & (~t1_all[2*k][TD1_CHAIN] | q0[2*k]);
      assign f1[2*k]   = q1[2*k]   & (~t1_all[2*k][TD1_CHAIN] | q1[2*k+1]);
      assign f1[2*k+1] = q1[2*k+1] & (~t1_all[2*k][TD1_CHAIN] | q1[2*k]);
   end
   assign win     = |f0 ? f0 : f1;
   assign hit_set = (state_q == IDLE) ? win : '0;
   for (genvar i = 0; i < NUM_TRIG; i++) begin : g_trig
      assign act[i] = t1_all[i][TD1_ACTION] & t1_all[i][TD1_DMODE];
      dec_trigger_reg u_reg (
         .clk     (clk),
         .rst     (rst),
         .dbg_mode(dbg_mode),
         .wr_en   (csr_wr_en && tsel_q == 2'(i)),
         .addr    (csr_addr),
         .wr_data (csr_wr_data),
         .hit_set (hit_set[i]),
         .fire    (win[i]),
         .tdata1  (t1_all[i]),
         .tdata2  (t2_all[i]),
         .hit_cnt (cnt_all[i]),
         .pkt     (trigger_pkt_any[i])
      );
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         halt_q  <= 1'b0;
         i1_q    <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         halt_q  <= halt_n;
         i1_q    <= i1_n;
      end
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      halt_n  = halt_q;
      i1_n    = i1_q;
      case (state_q)
         IDLE:  if (|win) begin
            state_n = PEND;
            halt_n  = |(win & act);
            i1_n    = ~|f0;
         end
         PEND:  if (trig_action_ack) begin
            state_n = FLUSH;
            cnt_n   = 3'(FLUSH_CYCLES - 1);
         end
         FLUSH: begin
            state_n = (cnt_q == '0) ? IDLE : FLUSH;
            cnt_n   = (cnt_q == '0) ? '0 : cnt_q - 3'd1;
         end
         default: state_n = IDLE;
      endcase
   end
   assign trig_action_req  = state_q == PEND;
   assign trig_action_halt = halt_q;
   assign trig_action_i1   = i1_q;
   assign csr_rd_data = csr_addr == CSR_TSELECT ? {30'd0, tsel_q} :
                        csr_addr == CSR_TDATA1  ? t1_all[tsel_q] :
                        csr_addr == CSR_TDATA2  ? t2_all[tsel_q] : {16'd0, cnt_all[tsel_q]};
endmodule
